// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite types and helpers
// Purpose: response codes and byte-address to word-index conversion shared by
// the AXI4-Lite slaves. No ports.
package axi_lite_pkg;

  // Fixed-width types of the original single-byte slave. They stay 12-bit and
  // 8-bit and are not meant for the parametrised buses.
  typedef logic [11:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // Drops the byte-offset bits; unaligned addresses land on their word.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input int data_width);
    return (data_width == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage

// File: rtl/axi_lite_ram_bank.sv
// rtl/axi_lite_ram_bank.sv - byte-enabled single-clock RAM with registered read
// Purpose: storage array with one byte-enabled write port and one registered
// read port. A read and a write to the same word at one edge return old data.
// Ports:
//   clk    in   clock
//   rst    in   async active-high reset, clears only the read register
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write data
//   wstrb  in   per-byte write enables
//   re     in   read enable, loads rdata
//   raddr  in   read word index
//   rdata  out  registered read data
module axi_lite_ram_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // The array itself is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we && wstrb[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Non-blocking read of the same array gives read-before-write ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// rtl/axi_lite_ram_slave.sv - parametrised AXI4-Lite RAM slave
// Purpose: word-organised RAM behind one AXI4-Lite slave port, with
// independent AW/W holding registers, byte strobes, concurrent read path and
// SLVERR for out-of-range words.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   awaddr/awvalid/awready       write address channel
//   wdata/wstrb/wvalid/wready    write data channel
//   bresp/bvalid/bready          write response channel
//   araddr/arvalid/arready       read address channel
//   rdata/rresp/rvalid/rready    read data channel
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output resp_t                   bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output resp_t                   rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [63:0]           w_index;
  logic [63:0]           r_index;
  logic                  w_in_range;
  logic                  r_in_range;
  logic                  rd_oor;
  logic [DATA_WIDTH-1:0] bank_rdata;

  assign awready = !areset && !aw_held;
  assign wready  = !areset && !w_held;
  assign arready = !areset && (!rvalid || rready);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Commit only once the previous response has left or is leaving this edge.
  assign commit = aw_held && w_held && (!bvalid || bready);

  assign w_index    = word_index(64'(aw_addr), DATA_WIDTH);
  assign r_index    = word_index(64'(araddr), DATA_WIDTH);
  assign w_in_range = w_index < 64'(DEPTH_WORDS);
  assign r_in_range = r_index < 64'(DEPTH_WORDS);

  // Write holding registers. A handshake needs an empty holder and commit
  // needs a full one, so both never apply to the same holder in one cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= awaddr;
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end else if (commit) begin
        w_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bready) begin
      bvalid <= 1'b0;
    end
  end

  // Read response. The bank's read register only loads on an in-range
  // handshake; rd_oor masks it to zero for out-of-range reads.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rd_oor <= 1'b0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      rd_oor <= !r_in_range;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

  assign rdata = rd_oor ? '0 : bank_rdata;

  axi_lite_ram_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (aclk),
    .rst   (areset),
    .we    (commit && w_in_range),
    .waddr (w_index[IDX_W-1:0]),
    .wdata (w_data),
    .wstrb (w_strb),
    .re    (ar_hs && r_in_range),
    .raddr (r_index[IDX_W-1:0]),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb/tb_axi_lite_ram_slave.sv - self-checking bench for axi_lite_ram_slave
module tb_axi_lite_ram_slave;

  localparam int DEPTH = 512;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];

  always #5 aclk = ~aclk;

  axi_lite_ram_slave #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  // Reference model: a word array indexed by byte address / 4.
  task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx < DEPTH) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      if (strb == 4'hF) known[idx] = 1'b1;
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [11:0] addr);
    return (int'(addr) / 4 < DEPTH) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    return (int'(addr) / 4 < DEPTH) ? ref_mem[int'(addr) / 4] : 32'h0;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          output logic [1:0] resp);
    int cyc;
    bit aw_done, w_done, aw_rdy, w_rdy, early_b, got;
    aw_done = 0; w_done = 0; early_b = 0; cyc = 0; got = 0;
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
    resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge aclk);
      aw_rdy = awvalid && awready;
      w_rdy  = wvalid && wready;
      if (bvalid) early_b = 1;
      @(posedge aclk); #1;
      if (aw_rdy) aw_done = 1;
      if (w_rdy) w_done = 1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++; $display("FAIL write_handshake addr=%h got timeout req accepted", addr);
    end
    checks++;
    if (early_b) begin
      errors++; $display("FAIL write_early_bvalid addr=%h got bvalid=1 req 0", addr);
    end
    cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge aclk);
      if (bvalid) begin got = 1; resp = bresp; end
      @(posedge aclk); #1;
      cyc++;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL write_bvalid_timeout addr=%h got none req bvalid", addr);
    end
  endtask

  task automatic do_read(input logic [11:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int cyc;
    bit done, rdy, got;
    done = 0; got = 0; cyc = 0;
    data = 'x; resp = 'x;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge aclk);
      rdy = arready;
      @(posedge aclk); #1;
      if (rdy) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL read_handshake addr=%h got timeout req accepted", addr);
    end
    lat = 0;
    while (!got && lat < 50) begin
      lat++;
      @(negedge aclk);
      if (rvalid) begin got = 1; data = rdata; resp = rresp; end
      @(posedge aclk); #1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL read_rvalid_timeout addr=%h got none req rvalid", addr);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL reset_awready got %b req 0", awready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b req 0", wready); end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready got %b req 0", arready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b req 0", bvalid); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b req 0", rvalid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp got %b req 00", bresp); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got %b req 00", rresp); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h req 0", rdata); end
    areset = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (!(awready && wready && arready)) begin
      errors++; $display("FAIL post_reset_ready got %b%b%b req 111", awready, wready, arready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic init_mem;
    logic [1:0] r;
    logic [31:0] d;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      do_write(12'(i * 4), d, 4'hF, 0, 0, r);
      model_write(12'(i * 4), d, 4'hF);
    end
  endtask

  task automatic test_basic;
    logic [31:0] d; logic [1:0] r; int lat;
    awaddr = 12'h010; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    checks++;
    if (!(awready && wready)) begin errors++; $display("FAIL basic_ready got %b%b req 11", awready, wready); end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL basic_bvalid_cycle1 got %b req 0", bvalid); end
    @(posedge aclk);
    @(negedge aclk);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL basic_bvalid_cycle2 got %b req 1", bvalid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b req 00", bresp); end
    @(posedge aclk); #1;
    model_write(12'h010, 32'hDEADBEEF, 4'hF);
    do_read(12'h010, d, r, lat);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got %h req deadbeef", d); end
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_rresp got %b req 00", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL basic_read_latency got %0d req 1", lat); end
  endtask

  task automatic test_strobe_order;
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(12'h010, 32'h11223344, 4'h5, 3, 0, r);
    model_write(12'h010, 32'h11223344, 4'h5);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL strobe_bresp got %b req 00", r); end
    do_read(12'h012, d, r, lat);
    checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_rdata got %h req de22be44", d); end
    checks++; if (d !== model_read(12'h010)) begin errors++; $display("FAIL strobe_model got %h req %h", d, model_read(12'h010)); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(12'h800, 32'hCAFEF00D, 4'hF, 0, 0, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b req 10", r); end
    do_read(12'h800, d, r, lat);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_rresp got %b req 10", r); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h req 0", d); end
    do_read(12'h000, d, r, lat);
    checks++; if (d !== model_read(12'h000)) begin errors++; $display("FAIL oor_word0 got %h req %h", d, model_read(12'h000)); end
  endtask

  task automatic test_bready_stall;
    logic [31:0] d1, d; logic [1:0] r; int lat;
    d1 = $urandom;
    bready = 1'b0;
    awaddr = 12'h030; wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge aclk); #1;
    awaddr = 12'h804; wdata = 32'h55AA55AA; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got bv=%b br=%b awr=%b wr=%b req 1 00 0 0", i, bvalid, bresp, awready, wready);
      end
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL stall_second_bvalid got %b req 1", bvalid); end
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL stall_second_bresp got %b req 10", bresp); end
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL stall_awready_free got %b req 1", awready); end
    @(posedge aclk);
    @(negedge aclk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL stall_bvalid_drop got %b req 0", bvalid); end
    @(posedge aclk); #1;
    model_write(12'h030, d1, 4'hF);
    do_read(12'h030, d, r, lat);
    checks++; if (d !== d1) begin errors++; $display("FAIL stall_readback got %h req %h", d, d1); end
  endtask

  task automatic test_raw_concurrent;
    logic [31:0] oldv, newv; logic [1:0] r;
    logic [31:0] exp [4];
    oldv = $urandom; newv = ~oldv;
    do_write(12'h020, oldv, 4'hF, 0, 0, r);
    model_write(12'h020, oldv, 4'hF);
    exp[0] = model_read(12'h020); exp[1] = model_read(12'h020);
    model_write(12'h020, newv, 4'hF);
    exp[2] = model_read(12'h020); exp[3] = model_read(12'h020);
    awaddr = 12'h020; wdata = newv; wstrb = 4'hF; araddr = 12'h020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    checks++;
    if (!(awready && wready && arready)) begin
      errors++; $display("FAIL raw_ready got %b%b%b req 111", awready, wready, arready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      if (i == 0) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (i == 3) arvalid = 1'b0;
      @(negedge aclk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp[i]) begin
        errors++; $display("FAIL raw_beat%0d got rv=%b %h req 1 %h", i + 1, rvalid, rdata, exp[i]);
      end
      if (i == 1) begin
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL raw_bvalid got %b req 1", bvalid); end
      end
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL raw_rvalid_end got %b req 0", rvalid); end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, nv; logic [1:0] r; int lat;
    rready = 1'b0;
    awaddr = 12'h040; awvalid = 1'b1; araddr = 12'h000; arvalid = 1'b1;
    wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rvalid got %b req 1", rvalid); end
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rstmid_pre_awheld got awready=%b req 0", awready); end
    areset = 1'b1;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %b req 0", rvalid); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rstmid_bvalid got %b req 0", bvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h req 0", rdata); end
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rstmid_awready got %b req 0", awready); end
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk); #1;
    rready = 1'b1;
    do_read(12'h040, d, r, lat);
    checks++; if (d !== model_read(12'h040)) begin errors++; $display("FAIL rstmid_unchanged got %h req %h", d, model_read(12'h040)); end
    nv = $urandom;
    do_write(12'h040, nv, 4'hF, 1, 0, r);
    model_write(12'h040, nv, 4'hF);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL rstmid_next_bresp got %b req 00", r); end
    do_read(12'h040, d, r, lat);
    checks++; if (d !== nv) begin errors++; $display("FAIL rstmid_next_rdata got %h req %h", d, nv); end
  endtask

  task automatic test_random;
    logic [11:0] addr; logic [31:0] d, rd; logic [3:0] s; logic [1:0] r; int lat;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) addr = 12'(12'h800 + $urandom_range(0, 12'h7FF));
      else addr = 12'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        do_write(addr, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r);
        model_write(addr, d, s);
        checks++;
        if (r !== model_resp(addr)) begin errors++; $display("FAIL rand_bresp addr=%h got %b req %b", addr, r, model_resp(addr)); end
      end else begin
        do_read(addr, rd, r, lat);
        checks++;
        if (r !== model_resp(addr) || rd !== model_read(addr)) begin
          errors++; $display("FAIL rand_read addr=%h got %h/%b req %h/%b", addr, rd, r, model_read(addr), model_resp(addr));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout req finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    init_mem();
    test_basic();
    test_strobe_order();
    test_out_of_range();
    test_bready_stall();
    test_raw_concurrent();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_ram_slave.md
# axi_lite_ram_slave

Parametrised AXI4-Lite memory slave: a word-organised RAM behind one AXI4-Lite slave port. It is the next generation of the team's single-byte, one-transaction-at-a-time slave, adding the following:
- configurable data width and depth
- byte strobes
- independent AW/W acceptance
- concurrent read and write paths
- SLVERR on out-of-range addresses

It sits behind the AXI4-Lite interconnect as a leaf target.

## Interface
- ADDR_WIDTH, 12, byte-address width.
- DATA_WIDTH, 32, data bus width. Legal values: 32 or 64.
- DEPTH_WORDS, 1024, number of DATA_WIDTH-bit words. Must satisfy DEPTH_WORDS*DATA_WIDTH/8 <= 2**ADDR_WIDTH.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  reset, asynchronous, active-high.
- awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.

## Operation
Addressing:
- Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. Low byte-offset bits are ignored; unaligned addresses are treated as aligned.
- Index >= DEPTH_WORDS is out of range.

Write path:
- Two one-entry holding registers, aw_held and w_held.
- awready = !areset && !aw_held. wready = !areset && !w_held.
- AW and W handshakes may occur in either order or in the same cycle. Each latches its payload and sets its held flag.
- Commit condition: aw_held && w_held && (!bvalid || bready).
- On commit, all at one edge:
  - Write the bytes whose wstrb bit is set.
  - Clear both held flags.
  - Set bvalid.
  - Set bresp = OKAY, or SLVERR if out of range. An out-of-range write changes no memory.
- bvalid holds until bready is sampled high.

Read path:
- arready = !areset && (!rvalid || rready).
- On AR handshake:
  - rdata = mem[index], or 0 if out of range.
  - rresp = OKAY or SLVERR.
  - rvalid = 1 at the next edge.
- rdata and rresp are stable while rvalid && !rready.

Concurrency and memory contents:
- The read and write paths are fully independent.
- If a commit and an AR handshake to the same word occur at the same edge, the read returns the pre-write data (read-before-write).
- Memory is not cleared by reset. Contents are undefined until written.

## Timing
Reset values:
- Asynchronous assertion clears aw_held, w_held, bvalid and rvalid.
- Reset values: bresp=0, rresp=0, rdata=0, bvalid=0, rvalid=0.
- All readys are 0 while areset=1.

Write and read latency:
- Write: AW and W accepted at edge N gives commit at edge N+1, so bvalid is high in the cycle after N+1.
- Write throughput: one write per 2 cycles.
- Read: AR accepted at edge N gives rvalid high in the cycle after N.
- Read throughput: back-to-back reads at 1 per cycle while rready=1.

Back-pressure:
- bready low stalls the commit.
- Holding registers stay full, and awready/wready stay low.

Reset mid-operation:
- In-flight transactions are dropped with no response.
- A write is either fully committed or not at all. No partial strobe writes occur.

## Structure
- Add to axi_lite_pkg:
  - resp_t (2 bits) with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Function word_index(addr, DATA_WIDTH).
- Existing package types that stay 12-bit/8-bit must not be used for the parametrised buses.
- One sub-module, axi_lite_ram_bank:
  - Synchronous single-clock RAM with one byte-enabled write port and one read port.
  - Registered read, read-before-write.
  - Parameters DATA_WIDTH and DEPTH_WORDS.

## Test plan
- AW 0x010 and W 0xDEADBEEF with wstrb 0xF in the same cycle, bready=1. Then AR 0x010, rready=1. Expected: bvalid 2 cycles after the handshake, bresp OKAY, then rdata 0xDEADBEEF with rresp OKAY 1 cycle after AR.
- W 0x11223344 with wstrb 0x5 to 0x010 (holding 0xDEADBEEF), with W three cycles before AW. Expected: readback 0xDE22BE44 and no bvalid before the AW handshake.
- Instantiate with DEPTH_WORDS=512. Write 0xCAFEF00D to 0x800, then read 0x800. Expected: bresp SLVERR, rresp SLVERR, rdata 0, and word 0 unchanged.
- Hold bready=0 for 5 cycles after a write. Expected: bvalid stays high, awready and wready drop after the next AW/W pair, and the second commit occurs only after bready rises.
- AR 0x020 on 4 consecutive cycles with rready=1, while a write to 0x020 commits on the same edge as the 2nd AR. Expected: 4 rvalid beats on consecutive cycles; beats 1-2 return old data and beats 3-4 return new data.
- Assert areset for 1 cycle while a write is held (AW accepted, W not yet) and rvalid=1. Expected: bvalid=0, rvalid=0 immediately, memory unchanged, and the next full write completes normally.
